axi_lite_reg_slave: RTL and testbench
=====================================

// Module: axi_lite_reg_slave
// PURPOSE
//  AXI4-Lite responder (slave end) terminating an axi_lite_interface link; exposes NUM_REGS
//  read/write 32-bit registers to the fabric. Used as a DUT-side register target for the
//  validation master. One outstanding write and one outstanding read; the channels run independently.
// PARAMETERS
//  DATA_WIDTH   32            data bus width; only 32 supported
//  ADDR_WIDTH   11            byte address width
//  NUM_REGS     16            number of registers, 1..2**(ADDR_WIDTH-2)
//  RESET_VALUE  32'h0000_0000 reset/initial value of every register
// PORTS
//  clk         in   1                    sole clock; all logic rising-edge
//  reset       in   1                    asynchronous, active-high reset
//  awvalid     in   1                    write address valid
//  awready     out  1                    write address ready
//  awprot      in   3                    ignored
//  awaddr      in   ADDR_WIDTH           write byte address
//  wvalid      in   1                    write data valid
//  wready      out  1                    write data ready
//  wstrb       in   DATA_WIDTH/8         byte lane enables
//  wdata       in   DATA_WIDTH           write data
//  bvalid      out  1                    write response valid
//  bready      in   1                    write response ready
//  bresp       out  2                    00 OKAY, 10 SLVERR
//  arvalid     in   1                    read address valid
//  arready     out  1                    read address ready
//  arprot      in   3                    ignored
//  araddr      in   ADDR_WIDTH           read byte address
//  rvalid      out  1                    read data valid
//  rready      in   1                    read data ready
//  rdata       out  DATA_WIDTH           read data
//  rresp       out  2                    00 OKAY, 10 SLVERR
//  reg_q       out  NUM_REGS*DATA_WIDTH  register contents; reg i = bits [i*32+:32]
//  reg_wr_stb  out  NUM_REGS             1-cycle pulse on the cycle after reg i is written
// BEHAVIOUR
//  - reset: all outputs 0 (including readies); reg_q = RESET_VALUE per reg; FSMs IDLE; flags clear.
//    Assertion mid-transaction aborts it instantly: bvalid/rvalid drop; pending AW/W are discarded.
//    Readies rise on the first clk edge after reset deasserts (registered ready_en flop).
//  - decode: idx = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored; idx >= NUM_REGS -> SLVERR.
//  - write FSM W_IDLE/W_RESP: in W_IDLE awready = ready_en & !aw_flag, wready = ready_en & !w_flag.
//    AW and W are accepted in either order or the same cycle; each is latched with its flag.
//    At the edge where W_IDLE & aw_flag & w_flag: commit write (byte lanes per wstrb; wstrb=0 is
//    legal, no change), pulse reg_wr_stb[idx] for one cycle, set bvalid/bresp, clear flags, go W_RESP.
//    Latency: last of AW/W handshakes at edge N -> reg updated and bvalid=1 after edge N+1.
//    W_RESP: awready=wready=0; bvalid held with bresp stable until bvalid&bready, then W_IDLE
//    (next AW may be accepted on the following cycle). Out-of-range: no reg change, no strobe, bresp=10.
//  - read FSM R_IDLE/R_RESP: arready = ready_en & R_IDLE. On arvalid&arready at edge N: rdata <=
//    reg[idx] (or 0 if out of range), rresp set, rvalid=1 after edge N, go R_RESP.
//    R_RESP: arready=0; rdata/rresp stable until rvalid&rready, then R_IDLE. rdata = 0 when !rvalid.
//  - simultaneous read and write commit to the same reg on edge N: read returns the pre-write value.
//  - back-pressure: bready/rready held low indefinitely stalls only the owning channel.
// TESTING
//  1 reset, AW 0x008 + W 0xDEADBEEF strb F same cycle -> bvalid 2 cycles later, bresp 00, reg2=DEADBEEF, stb[2] 1 cycle
//  2 W first (0x12345678, strb 0101), AW 0x00C 3 cycles later -> reg3=0x00340078 from reset 0; awready/wready low until B done
//  3 AR 0x008 after test 1 with rready low 5 cycles -> rvalid held, rdata=DEADBEEF stable, arready=0; single beat on rready
//  4 AW/AR 0x040 (idx16, NUM_REGS=16) -> bresp=10, no reg/stb change; rresp=10, rdata=0
//  5 write 0x55 to reg1 and AR reg1 committing same edge -> rdata=old value; next read returns 0x55
//  6 reset asserted while bvalid=1 awaiting bready -> bvalid=0 immediately, all regs=RESET_VALUE, readies 0 then 1

Source files
------------

// File: rtl/axi_lite_reg_slave_if.sv
// AXI4-Lite link between a bus master and a register target.
// Carries all five channels; clock and reset stay outside the bundle.
interface axi_lite_reg_slave_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
);
    logic                      awvalid;
    logic                      awready;
    logic [2:0]                awprot;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic [DATA_WIDTH-1:0]     wdata;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [2:0]                arprot;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;

    modport master (
        output awvalid, awprot, awaddr, wvalid, wstrb, wdata, bready,
               arvalid, arprot, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awprot, awaddr, wvalid, wstrb, wdata, bready,
               arvalid, arprot, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register target: NUM_REGS 32-bit read/write registers, one outstanding
// write and one outstanding read, with independent write and read state machines.
module axi_lite_reg_slave #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 11,
    parameter int                    NUM_REGS    = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    axi_lite_reg_slave_if.slave            bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr_stb
);
    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int SEL_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [IDX_W:0] REG_COUNT = (IDX_W + 1)'(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_RESP } r_state_t;

    w_state_t              w_state;
    r_state_t              r_state;
    logic                  ready_en;
    logic                  aw_flag;
    logic                  w_flag;
    logic [IDX_W-1:0]      aw_idx;
    logic [DATA_WIDTH-1:0] wdata_l;
    logic [STRB_W-1:0]     wstrb_l;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [IDX_W-1:0]      ar_idx;
    logic [SEL_W-1:0]      ar_sel;
    logic [SEL_W-1:0]      aw_sel;
    logic                  unused_bits;

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return {1'b0, idx} < REG_COUNT;
    endfunction

    assign ar_idx = bus.araddr[ADDR_WIDTH-1:2];
    assign ar_sel = ar_idx[SEL_W-1:0];
    assign aw_sel = aw_idx[SEL_W-1:0];
    assign unused_bits = ^{bus.awprot, bus.arprot, bus.awaddr[1:0], bus.araddr[1:0]};

    // Readies come up one edge after reset release, never combinationally from reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ready_en <= 1'b0;
        else       ready_en <= 1'b1;
    end

    assign bus.awready = ready_en & (w_state == W_IDLE) & ~aw_flag;
    assign bus.wready  = ready_en & (w_state == W_IDLE) & ~w_flag;
    assign bus.arready = ready_en & (r_state == R_IDLE);

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_q
            assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state    <= W_IDLE;
            aw_flag    <= 1'b0;
            w_flag     <= 1'b0;
            aw_idx     <= '0;
            wdata_l    <= '0;
            wstrb_l    <= '0;
            bus.bvalid <= 1'b0;
            bus.bresp  <= RESP_OKAY;
            reg_wr_stb <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
        end else begin
            reg_wr_stb <= '0;
            case (w_state)
                W_IDLE: begin
                    if (bus.awvalid && bus.awready) begin
                        aw_flag <= 1'b1;
                        aw_idx  <= bus.awaddr[ADDR_WIDTH-1:2];
                    end
                    if (bus.wvalid && bus.wready) begin
                        w_flag  <= 1'b1;
                        wdata_l <= bus.wdata;
                        wstrb_l <= bus.wstrb;
                    end
                    // Both halves latched: readies are already low, so no new beat can collide.
                    if (aw_flag && w_flag) begin
                        if (in_range(aw_idx)) begin
                            for (int b = 0; b < STRB_W; b++) begin
                                if (wstrb_l[b]) regs[aw_sel][b*8 +: 8] <= wdata_l[b*8 +: 8];
                            end
                            reg_wr_stb[aw_sel] <= 1'b1;
                            bus.bresp <= RESP_OKAY;
                        end else begin
                            bus.bresp <= RESP_SLVERR;
                        end
                        bus.bvalid <= 1'b1;
                        aw_flag    <= 1'b0;
                        w_flag     <= 1'b0;
                        w_state    <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bus.bready) begin
                        bus.bvalid <= 1'b0;
                        w_state    <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Reads sample regs before this edge's write commit, so a colliding read sees the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= R_IDLE;
            bus.rvalid <= 1'b0;
            bus.rdata  <= '0;
            bus.rresp  <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (bus.arvalid && bus.arready) begin
                        if (in_range(ar_idx)) begin
                            bus.rdata <= regs[ar_sel];
                            bus.rresp <= RESP_OKAY;
                        end else begin
                            bus.rdata <= '0;
                            bus.rresp <= RESP_SLVERR;
                        end
                        bus.rvalid <= 1'b1;
                        r_state    <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (bus.rready) begin
                        bus.rvalid <= 1'b0;
                        bus.rdata  <= '0;
                        r_state    <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave: handshake timing, byte strobes, back-pressure,
// out-of-range decode, read/write collision and mid-transaction reset.
module tb_axi_lite_reg_slave;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [511:0] reg_q;
    logic [15:0]  reg_wr_stb;
    logic [31:0]  exp_regs [16];
    int           n_checks = 0;
    int           n_fail = 0;

    axi_lite_reg_slave_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) bus ();

    axi_lite_reg_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(11), .NUM_REGS(16), .RESET_VALUE(32'h0000_0000)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .reg_q(reg_q), .reg_wr_stb(reg_wr_stb)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [511:0] exp_vec();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = exp_regs[i];
        return v;
    endfunction

    // Issues AW and W together, completes B; called at a negedge.
    task automatic do_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s);
        logic aw_hs, w_hs;
        int   t;
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        t = 0;
        while ((bus.awvalid || bus.wvalid) && t < 20) begin
            aw_hs = bus.awvalid & bus.awready;
            w_hs  = bus.wvalid & bus.wready;
            @(negedge clk); t++;
            if (aw_hs) bus.awvalid = 1'b0;
            if (w_hs)  bus.wvalid = 1'b0;
        end
        while (!bus.bvalid && t < 40) begin @(negedge clk); t++; end
        n_checks++;
        if (bus.bvalid !== 1'b1) begin n_fail++; $display("FAIL do_write_timeout: bvalid=%b required 1", bus.bvalid); end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b1; @(negedge clk); bus.bready = 1'b0;
    endtask

    task automatic do_read(input logic [10:0] a, output logic [31:0] d, output logic [1:0] r);
        int t;
        bus.araddr = a; bus.arvalid = 1'b1;
        t = 0;
        while (!bus.arready && t < 20) begin @(negedge clk); t++; end
        @(negedge clk);
        bus.arvalid = 1'b0;
        while (!bus.rvalid && t < 40) begin @(negedge clk); t++; end
        n_checks++;
        if (bus.rvalid !== 1'b1) begin n_fail++; $display("FAIL do_read_timeout: rvalid=%b required 1", bus.rvalid); end
        d = bus.rdata; r = bus.rresp;
        bus.rready = 1'b1; @(negedge clk); bus.rready = 1'b0;
    endtask

    task automatic test_reset;
        bus.awvalid = 0; bus.awprot = 0; bus.awaddr = 0; bus.wvalid = 0; bus.wstrb = 0; bus.wdata = 0;
        bus.bready = 0; bus.arvalid = 0; bus.arprot = 0; bus.araddr = 0; bus.rready = 0;
        for (int i = 0; i < 16; i++) exp_regs[i] = 32'h0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin n_fail++; $display("FAIL rst_readies: got %b required 000", {bus.awready, bus.wready, bus.arready}); end
        n_checks++; if ({bus.bvalid, bus.rvalid} !== 2'b00) begin n_fail++; $display("FAIL rst_valids: got %b required 00", {bus.bvalid, bus.rvalid}); end
        n_checks++; if (reg_q !== exp_vec()) begin n_fail++; $display("FAIL rst_reg_q: got %h required %h", reg_q, exp_vec()); end
        n_checks++; if (reg_wr_stb !== 16'h0) begin n_fail++; $display("FAIL rst_stb: got %h required 0000", reg_wr_stb); end
        reset = 1'b0;
        #1;
        n_checks++; if (bus.awready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_delay: awready=%b required 0", bus.awready); end
        @(negedge clk);
        n_checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin n_fail++; $display("FAIL rst_ready_up: got %b required 111", {bus.awready, bus.wready, bus.arready}); end
    endtask

    task automatic test_write_same_cycle;
        bus.awaddr = 11'h008; bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        n_checks++; if (bus.bvalid !== 1'b0) begin n_fail++; $display("FAIL t1_bvalid_early: got %b required 0", bus.bvalid); end
        n_checks++; if ({bus.awready, bus.wready} !== 2'b00) begin n_fail++; $display("FAIL t1_ready_latched: got %b required 00", {bus.awready, bus.wready}); end
        @(negedge clk);
        exp_regs[2] = 32'hDEADBEEF;
        n_checks++; if (bus.bvalid !== 1'b1) begin n_fail++; $display("FAIL t1_bvalid: got %b required 1", bus.bvalid); end
        n_checks++; if (bus.bresp !== 2'b00) begin n_fail++; $display("FAIL t1_bresp: got %b required 00", bus.bresp); end
        n_checks++; if (reg_q !== exp_vec()) begin n_fail++; $display("FAIL t1_reg_q: got %h required %h", reg_q, exp_vec()); end
        n_checks++; if (reg_wr_stb !== 16'h0004) begin n_fail++; $display("FAIL t1_stb: got %h required 0004", reg_wr_stb); end
        @(negedge clk);
        n_checks++; if (reg_wr_stb !== 16'h0000) begin n_fail++; $display("FAIL t1_stb_pulse: got %h required 0000", reg_wr_stb); end
        n_checks++; if (bus.bvalid !== 1'b1) begin n_fail++; $display("FAIL t1_bvalid_hold: got %b required 1", bus.bvalid); end
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        n_checks++; if (bus.bvalid !== 1'b0) begin n_fail++; $display("FAIL t1_bvalid_done: got %b required 0", bus.bvalid); end
        n_checks++; if (bus.awready !== 1'b1) begin n_fail++; $display("FAIL t1_awready_back: got %b required 1", bus.awready); end
    endtask

    task automatic test_w_before_aw;
        bus.wdata = 32'h12345678; bus.wstrb = 4'b0101; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.wvalid = 1'b0;
        n_checks++; if ({bus.wready, bus.awready} !== 2'b01) begin n_fail++; $display("FAIL t2_w_latched: wready,awready=%b required 01", {bus.wready, bus.awready}); end
        @(negedge clk);
        n_checks++; if (bus.wready !== 1'b0) begin n_fail++; $display("FAIL t2_wready_wait1: got %b required 0", bus.wready); end
        @(negedge clk);
        n_checks++; if ({bus.wready, bus.bvalid} !== 2'b00) begin n_fail++; $display("FAIL t2_wait2: wready,bvalid=%b required 00", {bus.wready, bus.bvalid}); end
        bus.awaddr = 11'h00C; bus.awvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        n_checks++; if ({bus.awready, bus.bvalid} !== 2'b00) begin n_fail++; $display("FAIL t2_aw_latched: awready,bvalid=%b required 00", {bus.awready, bus.bvalid}); end
        @(negedge clk);
        exp_regs[3] = 32'h00340078;
        n_checks++; if (bus.bvalid !== 1'b1) begin n_fail++; $display("FAIL t2_bvalid: got %b required 1", bus.bvalid); end
        n_checks++; if (reg_q !== exp_vec()) begin n_fail++; $display("FAIL t2_reg_q: got %h required %h", reg_q, exp_vec()); end
        n_checks++; if (reg_wr_stb !== 16'h0008) begin n_fail++; $display("FAIL t2_stb: got %h required 0008", reg_wr_stb); end
        @(negedge clk);
        n_checks++; if ({bus.awready, bus.wready} !== 2'b00) begin n_fail++; $display("FAIL t2_resp_readies: got %b required 00", {bus.awready, bus.wready}); end
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        n_checks++; if (bus.bvalid !== 1'b0) begin n_fail++; $display("FAIL t2_bvalid_done: got %b required 0", bus.bvalid); end
    endtask

    task automatic test_read_backpressure;
        n_checks++; if (bus.arready !== 1'b1) begin n_fail++; $display("FAIL t3_arready_idle: got %b required 1", bus.arready); end
        bus.araddr = 11'h008; bus.arvalid = 1'b1;
        @(negedge clk);
        bus.arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if ({bus.rvalid, bus.arready} !== 2'b10) begin n_fail++; $display("FAIL t3_stall_%0d: rvalid,arready=%b required 10", i, {bus.rvalid, bus.arready}); end
            n_checks++; if (bus.rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL t3_rdata_%0d: got %h required deadbeef", i, bus.rdata); end
            @(negedge clk);
        end
        n_checks++; if (bus.rresp !== 2'b00) begin n_fail++; $display("FAIL t3_rresp: got %b required 00", bus.rresp); end
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        n_checks++; if ({bus.rvalid, bus.arready} !== 2'b01) begin n_fail++; $display("FAIL t3_done: rvalid,arready=%b required 01", {bus.rvalid, bus.arready}); end
        n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL t3_rdata_idle: got %h required 0", bus.rdata); end
        @(negedge clk);
        n_checks++; if (bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL t3_single_beat: rvalid=%b required 0", bus.rvalid); end
    endtask

    task automatic test_out_of_range;
        bus.awaddr = 11'h040; bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge clk);
        n_checks++; if ({bus.bvalid, bus.bresp} !== 3'b110) begin n_fail++; $display("FAIL t4_bresp: bvalid,bresp=%b required 110", {bus.bvalid, bus.bresp}); end
        n_checks++; if (reg_wr_stb !== 16'h0) begin n_fail++; $display("FAIL t4_stb: got %h required 0000", reg_wr_stb); end
        n_checks++; if (reg_q !== exp_vec()) begin n_fail++; $display("FAIL t4_reg_q: got %h required %h", reg_q, exp_vec()); end
        bus.bready = 1'b1; @(negedge clk); bus.bready = 1'b0;
        bus.araddr = 11'h040; bus.arvalid = 1'b1;
        @(negedge clk);
        bus.arvalid = 1'b0;
        n_checks++; if ({bus.rvalid, bus.rresp} !== 3'b110) begin n_fail++; $display("FAIL t4_rresp: rvalid,rresp=%b required 110", {bus.rvalid, bus.rresp}); end
        n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL t4_rdata: got %h required 0", bus.rdata); end
        bus.rready = 1'b1; @(negedge clk); bus.rready = 1'b0;
    endtask

    task automatic test_read_write_collision;
        logic [31:0] d;
        logic [1:0]  r;
        do_write(11'h004, 32'hA5A5A5A5, 4'hF);
        exp_regs[1] = 32'hA5A5A5A5;
        bus.awaddr = 11'h004; bus.wdata = 32'h00000055; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.araddr = 11'h004; bus.arvalid = 1'b1;
        @(negedge clk);
        bus.arvalid = 1'b0;
        exp_regs[1] = 32'h00000055;
        n_checks++; if ({bus.rvalid, bus.bvalid} !== 2'b11) begin n_fail++; $display("FAIL t5_both_valid: rvalid,bvalid=%b required 11", {bus.rvalid, bus.bvalid}); end
        n_checks++; if (bus.rdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL t5_old_value: got %h required a5a5a5a5", bus.rdata); end
        n_checks++; if (reg_wr_stb !== 16'h0002) begin n_fail++; $display("FAIL t5_stb: got %h required 0002", reg_wr_stb); end
        n_checks++; if (reg_q !== exp_vec()) begin n_fail++; $display("FAIL t5_reg_q: got %h required %h", reg_q, exp_vec()); end
        bus.rready = 1'b1; bus.bready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0; bus.bready = 1'b0;
        do_read(11'h004, d, r);
        n_checks++; if ({r, d} !== {2'b00, 32'h00000055}) begin n_fail++; $display("FAIL t5_new_value: resp,data=%b,%h required 00,00000055", r, d); end
        do_read(11'h00E, d, r);
        n_checks++; if (d !== 32'h00340078) begin n_fail++; $display("FAIL t5_addr_lsbs: got %h required 00340078", d); end
    endtask

    task automatic test_reset_mid_txn;
        logic [31:0] d;
        logic [1:0]  r;
        bus.awaddr = 11'h014; bus.wdata = 32'h11111111; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (bus.bvalid !== 1'b1) begin n_fail++; $display("FAIL t6_bvalid_wait: got %b required 1", bus.bvalid); end
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) exp_regs[i] = 32'h0;
        n_checks++; if (bus.bvalid !== 1'b0) begin n_fail++; $display("FAIL t6_bvalid_abort: got %b required 0", bus.bvalid); end
        n_checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin n_fail++; $display("FAIL t6_readies_rst: got %b required 000", {bus.awready, bus.wready, bus.arready}); end
        n_checks++; if (reg_q !== exp_vec()) begin n_fail++; $display("FAIL t6_reg_q: got %h required %h", reg_q, exp_vec()); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++; if (bus.awready !== 1'b0) begin n_fail++; $display("FAIL t6_ready_delay: got %b required 0", bus.awready); end
        @(negedge clk);
        n_checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin n_fail++; $display("FAIL t6_readies_up: got %b required 111", {bus.awready, bus.wready, bus.arready}); end
        do_read(11'h008, d, r);
        n_checks++; if ({r, d} !== {2'b00, 32'h0}) begin n_fail++; $display("FAIL t6_reg2_cleared: resp,data=%b,%h required 00,00000000", r, d); end
    endtask

    initial begin
        test_reset();
        test_write_same_cycle();
        test_w_before_aw();
        test_read_backpressure();
        test_out_of_range();
        test_read_write_collision();
        test_reset_mid_txn();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
